// File: rtl/colour_lut_pkg.sv
// Shared definitions for the colour LUT loader: FSM state encodings, entry
// byte-count and download-window helpers.
package colour_lut_pkg;

  // Loader FSM states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_PEND    = 3'd2;
  localparam logic [2:0] ST_WRITE   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Bytes per LUT entry (little-endian, whole bytes)
  function automatic int unsigned bytes_per_entry(input int unsigned cw);
    return (cw + 32'd7) / 32'd8;
  endfunction

  // First download address past the table
  function automatic int unsigned win_end(input int unsigned base,
                                          input int unsigned pw,
                                          input int unsigned cw);
    return base + (32'd1 << pw) * bytes_per_entry(cw);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with synchronous flush.
// Ports: clk/rst_n, flush (empties, wins over push/pop), push/din, pop/dout
// (dout shows head while non-empty), avail (registered !full), empty (registered).
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       avail,
  output logic       empty
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = PTRW + 1;

  logic [7:0]      mem [DEPTH];
  logic [PTRW-1:0] wptr;
  logic [PTRW-1:0] rptr;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nxt;
  logic            do_push;
  logic            do_pop;

  // Qualified push/pop and next occupancy
  always_comb begin
    do_push = push & avail & ~flush;
    do_pop  = pop & ~empty & ~flush;
    cnt_nxt = cnt;
    if (flush) begin
      cnt_nxt = '0;
    end else if (do_push && !do_pop) begin
      cnt_nxt = cnt + CNTW'(1);
    end else if (do_pop && !do_push) begin
      cnt_nxt = cnt - CNTW'(1);
    end
  end

  // Pointers and registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      avail <= 1'b1;
      empty <= 1'b1;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_push) wptr <= wptr + PTRW'(1);
        if (do_pop)  rptr <= rptr + PTRW'(1);
      end
      cnt   <= cnt_nxt;
      avail <= (cnt_nxt != CNTW'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  // Storage, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  assign dout = mem[rptr];

endmodule

// File: rtl/colour_lut_loader.sv
// Colour LUT loader: buffers the download byte stream, assembles CW-bit
// entries and issues one LUT write per entry only while blank or video_off.
// Ports: download side dl_en/dl_addr/dl_data/dl_wr/dl_ready; video timing
// blank/video_off; LUT write port lut_wr/lut_addr/lut_din; status
// lut_valid/load_busy/load_err.
module colour_lut_loader
  import colour_lut_pkg::*;
#(
  parameter int unsigned PW     = 5,
  parameter int unsigned CW     = 8,
  parameter int unsigned AW     = 24,
  parameter int unsigned BASE   = 0,
  parameter int unsigned FDEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dl_en,
  input  logic [AW-1:0] dl_addr,
  input  logic [7:0]    dl_data,
  input  logic          dl_wr,
  output logic          dl_ready,
  input  logic          blank,
  input  logic          video_off,
  output logic          lut_wr,
  output logic [PW-1:0] lut_addr,
  output logic [CW-1:0] lut_din,
  output logic          lut_valid,
  output logic          load_busy,
  output logic          load_err
);

  localparam int unsigned BYTES = bytes_per_entry(CW);
  localparam int unsigned TOTAL = win_end(BASE, PW, CW) - BASE;
  localparam int unsigned EW    = BYTES * 8;
  localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [2:0]     state, state_nxt;
  logic           dl_en_q;
  logic [AW-1:0]  exp_off, exp_off_nxt;
  logic [BCW-1:0] byte_cnt, byte_cnt_nxt;
  logic [PW-1:0]  entry_cnt, entry_cnt_nxt;
  logic [EW-1:0]  entry, entry_nxt;
  logic           lut_wr_nxt;
  logic [PW-1:0]  lut_addr_nxt;
  logic [CW-1:0]  lut_din_nxt;
  logic           lut_valid_nxt;
  logic           load_err_nxt;
  logic           load_busy_nxt;

  logic           push_c, pop_c, flush_c;
  logic [7:0]     fifo_dout;
  logic           fifo_empty;
  logic           rise_c, fall_c, active_c, in_win_c;
  logic [AW-1:0]  off_c;

  byte_fifo #(.DEPTH(FDEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_c),
    .push  (push_c),
    .din   (dl_data),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .avail (dl_ready),
    .empty (fifo_empty)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_nxt     = state;
    exp_off_nxt   = exp_off;
    byte_cnt_nxt  = byte_cnt;
    entry_cnt_nxt = entry_cnt;
    entry_nxt     = entry;
    lut_wr_nxt    = 1'b0;
    lut_addr_nxt  = lut_addr;
    lut_din_nxt   = lut_din;
    lut_valid_nxt = lut_valid;
    load_err_nxt  = load_err;
    push_c        = 1'b0;
    pop_c         = 1'b0;
    flush_c       = 1'b0;

    rise_c   = dl_en & ~dl_en_q;
    fall_c   = ~dl_en & dl_en_q;
    active_c = (state == ST_COLLECT) || (state == ST_PEND) || (state == ST_WRITE);
    // Wrapping subtraction puts addresses below BASE far outside the window
    off_c    = dl_addr - AW'(BASE);
    in_win_c = ({1'b0, off_c} < (AW+1)'(TOTAL));

    if (rise_c) begin
      // New session restarts everything, even a pending write
      flush_c       = 1'b1;
      state_nxt     = ST_COLLECT;
      exp_off_nxt   = '0;
      byte_cnt_nxt  = '0;
      entry_cnt_nxt = '0;
      lut_valid_nxt = 1'b0;
      load_err_nxt  = 1'b0;
    end else if (fall_c) begin
      flush_c = 1'b1;
      if (active_c) begin
        load_err_nxt  = 1'b1;
        lut_valid_nxt = 1'b0;
      end
      state_nxt = ST_IDLE;
    end else begin
      // Accept only the next sequential in-window byte
      if (dl_wr && dl_ready && active_c && in_win_c) begin
        if (off_c == exp_off) begin
          push_c      = 1'b1;
          exp_off_nxt = exp_off + AW'(1);
        end else begin
          load_err_nxt = 1'b1;
        end
      end

      case (state)
        ST_COLLECT: begin
          if (!fifo_empty) begin
            pop_c = 1'b1;
            for (int unsigned b = 0; b < BYTES; b++) begin
              if (byte_cnt == BCW'(b)) entry_nxt[b*8 +: 8] = fifo_dout;
            end
            if (byte_cnt == BCW'(BYTES - 1)) begin
              byte_cnt_nxt = '0;
              state_nxt    = ST_PEND;
            end else begin
              byte_cnt_nxt = byte_cnt + BCW'(1);
            end
          end
        end
        ST_PEND: begin
          if (blank || video_off) begin
            state_nxt    = ST_WRITE;
            lut_wr_nxt   = 1'b1;
            lut_addr_nxt = entry_cnt;
            lut_din_nxt  = entry[CW-1:0];
          end
        end
        ST_WRITE: begin
          entry_cnt_nxt = entry_cnt + PW'(1);
          if (entry_cnt == {PW{1'b1}}) begin
            state_nxt     = ST_DONE;
            lut_valid_nxt = 1'b1;
          end else begin
            state_nxt = ST_COLLECT;
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_nxt = ST_IDLE;
      endcase
    end

    load_busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dl_en_q   <= 1'b0;
      exp_off   <= '0;
      byte_cnt  <= '0;
      entry_cnt <= '0;
      entry     <= '0;
      lut_wr    <= 1'b0;
      lut_addr  <= '0;
      lut_din   <= '0;
      lut_valid <= 1'b0;
      load_err  <= 1'b0;
      load_busy <= 1'b0;
    end else begin
      state     <= state_nxt;
      dl_en_q   <= dl_en;
      exp_off   <= exp_off_nxt;
      byte_cnt  <= byte_cnt_nxt;
      entry_cnt <= entry_cnt_nxt;
      entry     <= entry_nxt;
      lut_wr    <= lut_wr_nxt;
      lut_addr  <= lut_addr_nxt;
      lut_din   <= lut_din_nxt;
      lut_valid <= lut_valid_nxt;
      load_err  <= load_err_nxt;
      load_busy <= load_busy_nxt;
    end
  end

endmodule

// File: tb/tb_colour_lut_loader.sv
// Directed bench for colour_lut_loader: a CW=8 instance carries most checks,
// a CW=12 instance on the same inputs checks two-byte entry assembly.
module tb_colour_lut_loader;

  logic        clk;
  logic        rst_n;
  logic        dl_en;
  logic [23:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wr;
  logic        blank;
  logic        video_off;

  logic        dl_ready8, lut_wr8, lut_valid8, load_busy8, load_err8;
  logic [4:0]  lut_addr8;
  logic [7:0]  lut_din8;
  logic        dl_ready12, lut_wr12, lut_valid12, load_busy12, load_err12;
  logic [4:0]  lut_addr12;
  logic [11:0] lut_din12;

  int checks;
  int failures;
  int base8;
  int base12;

  logic [4:0]  q_a8[$];
  logic [7:0]  q_d8[$];
  logic [4:0]  q_a12[$];
  logic [11:0] q_d12[$];

  colour_lut_loader #(.PW(5), .CW(8), .AW(24), .BASE(0), .FDEPTH(4)) u8 (
    .clk(clk), .rst_n(rst_n), .dl_en(dl_en), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_wr(dl_wr), .dl_ready(dl_ready8), .blank(blank), .video_off(video_off),
    .lut_wr(lut_wr8), .lut_addr(lut_addr8), .lut_din(lut_din8),
    .lut_valid(lut_valid8), .load_busy(load_busy8), .load_err(load_err8)
  );

  colour_lut_loader #(.PW(5), .CW(12), .AW(24), .BASE(0), .FDEPTH(4)) u12 (
    .clk(clk), .rst_n(rst_n), .dl_en(dl_en), .dl_addr(dl_addr), .dl_data(dl_data),
    .dl_wr(dl_wr), .dl_ready(dl_ready12), .blank(blank), .video_off(video_off),
    .lut_wr(lut_wr12), .lut_addr(lut_addr12), .lut_din(lut_din12),
    .lut_valid(lut_valid12), .load_busy(load_busy12), .load_err(load_err12)
  );

  always #5 clk = ~clk;

  // Record every LUT write seen on either instance
  always @(negedge clk) begin
    if (lut_wr8) begin
      q_a8.push_back(lut_addr8);
      q_d8.push_back(lut_din8);
    end
    if (lut_wr12) begin
      q_a12.push_back(lut_addr12);
      q_d12.push_back(lut_din12);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, req);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Offer one byte (called at a negedge), hold until accepted by u8
  task automatic send(input logic [23:0] a, input logic [7:0] d);
    int t;
    t = 0;
    dl_addr = a;
    dl_data = d;
    dl_wr   = 1'b1;
    while (!dl_ready8 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t == 100) check("send_timeout", 32'(dl_ready8), 32'd1);
    @(posedge clk);
    @(negedge clk);
    dl_wr = 1'b0;
  endtask

  task automatic wait_wr8(input int target);
    for (int i = 0; i < 400; i++) begin
      if (q_a8.size() >= target) break;
      @(negedge clk);
    end
  endtask

  task automatic restart;
    dl_en = 1'b0;
    @(negedge clk);
    dl_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    clk = 1'b0; rst_n = 1'b0; dl_en = 1'b0; dl_addr = '0; dl_data = '0;
    dl_wr = 1'b0; blank = 1'b1; video_off = 1'b0;
    cycles(3);

    // Reset state
    check("rst_dl_ready",  32'(dl_ready8), 32'd1);
    check("rst_lut_wr",    32'(lut_wr8), 32'd0);
    check("rst_lut_addr",  32'(lut_addr8), 32'd0);
    check("rst_lut_din",   32'(lut_din8), 32'd0);
    check("rst_flags",     32'({lut_valid8, load_busy8, load_err8}), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Full table of 32 entries, data i at address i
    base8 = q_a8.size();
    dl_en = 1'b1;
    @(negedge clk);
    check("sess_busy", 32'(load_busy8), 32'd1);
    for (int i = 0; i < 32; i++) send(24'(i), 8'(i));
    wait_wr8(base8 + 32);
    cycles(3);
    check("full_count", 32'(q_a8.size() - base8), 32'd32);
    for (int i = 0; i < 32; i++) begin
      check("full_addr", 32'(q_a8[base8 + i]), 32'(i));
      check("full_data", 32'(q_d8[base8 + i]), 32'(i));
    end
    check("full_valid", 32'(lut_valid8), 32'd1);
    check("full_busy",  32'(load_busy8), 32'd0);
    check("full_err",   32'(load_err8), 32'd0);
    dl_en = 1'b0;
    cycles(2);
    check("done_fall_valid", 32'(lut_valid8), 32'd1);
    check("done_fall_err",   32'(load_err8), 32'd0);

    // CW=12: little-endian pair 0x34,0x12 gives 0x234 at index 0
    base12 = q_a12.size();
    dl_en = 1'b1;
    @(negedge clk);
    send(24'd0, 8'h34);
    send(24'd1, 8'h12);
    cycles(6);
    check("cw12_count", 32'(q_a12.size() - base12), 32'd1);
    check("cw12_addr",  32'(q_a12[base12]), 32'd0);
    check("cw12_data",  32'(q_d12[base12]), 32'h234);

    // Blank gating: entry waits, one-cycle blank pulse releases exactly one write
    restart();
    blank = 1'b0;
    base8 = q_a8.size();
    send(24'd0, 8'h5A);
    cycles(6);
    check("gate_no_wr", 32'(q_a8.size() - base8), 32'd0);
    check("gate_busy",  32'(load_busy8), 32'd1);
    check("gate_valid", 32'(lut_valid8), 32'd0);
    blank = 1'b1;
    @(negedge clk);
    blank = 1'b0;
    check("gate_wr_pulse", 32'(lut_wr8), 32'd1);
    cycles(5);
    check("gate_once", 32'(q_a8.size() - base8), 32'd1);
    check("gate_addr", 32'(q_a8[base8]), 32'd0);
    check("gate_data", 32'(q_d8[base8]), 32'h5A);

    // Burst with blank low: five bytes taken (one in PEND, four queued), then full
    base8 = q_a8.size();
    for (int i = 1; i <= 5; i++) send(24'(i), 8'(8'hA0 + i));
    check("burst_full",  32'(dl_ready8), 32'd0);
    check("burst_no_wr", 32'(q_a8.size() - base8), 32'd0);
    blank = 1'b1;
    for (int i = 6; i <= 8; i++) send(24'(i), 8'(8'hA0 + i));
    wait_wr8(base8 + 8);
    cycles(4);
    check("burst_count", 32'(q_a8.size() - base8), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("burst_addr", 32'(q_a8[base8 + i]), 32'(i + 1));
      check("burst_data", 32'(q_d8[base8 + i]), 32'(8'hA1 + i));
    end
    check("burst_ready", 32'(dl_ready8), 32'd1);

    // Skipped offset 3, writes released by video_off instead of blank
    restart();
    blank = 1'b0;
    video_off = 1'b1;
    base8 = q_a8.size();
    send(24'd0, 8'h10);
    send(24'd1, 8'h11);
    send(24'd2, 8'h12);
    send(24'd4, 8'h14);
    cycles(10);
    check("skip_err",   32'(load_err8), 32'd1);
    check("skip_count", 32'(q_a8.size() - base8), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("skip_addr", 32'(q_a8[base8 + i]), 32'(i));
      check("skip_data", 32'(q_d8[base8 + i]), 32'(8'h10 + i));
    end
    check("skip_valid", 32'(lut_valid8), 32'd0);

    // Abort after ten entries
    restart();
    video_off = 1'b0;
    blank = 1'b1;
    base8 = q_a8.size();
    check("abort_err_cleared", 32'(load_err8), 32'd0);
    for (int i = 0; i < 10; i++) send(24'(i), 8'(8'h40 + i));
    wait_wr8(base8 + 10);
    cycles(3);
    check("abort_count", 32'(q_a8.size() - base8), 32'd10);
    check("abort_busy_before", 32'(load_busy8), 32'd1);
    dl_en = 1'b0;
    cycles(2);
    check("abort_err",   32'(load_err8), 32'd1);
    check("abort_valid", 32'(lut_valid8), 32'd0);
    check("abort_busy",  32'(load_busy8), 32'd0);

    // Reset while an entry is pending
    dl_en = 1'b1;
    @(negedge clk);
    blank = 1'b0;
    base8 = q_a8.size();
    send(24'd0, 8'h77);
    cycles(4);
    check("pend_busy", 32'(load_busy8), 32'd1);
    rst_n = 1'b0;
    dl_en = 1'b0;
    blank = 1'b1;
    #1;
    check("mid_rst_flags", 32'({lut_wr8, lut_valid8, load_busy8, load_err8}), 32'd0);
    check("mid_rst_ready", 32'(dl_ready8), 32'd1);
    cycles(3);
    rst_n = 1'b1;
    cycles(5);
    check("mid_rst_no_wr", 32'(q_a8.size() - base8), 32'd0);
    check("mid_rst_busy",  32'(load_busy8), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
